// File: rtl/shapool_host_spi.sv
// Host-side SPI master for a SHA pool: shifts a job word out on the global bus,
// waits for the pool's ready_n flag, then reads the result back over the daisy bus.
module shapool_host_spi #(
  parameter int JOB_BITS    = 352,
  parameter int RESULT_BITS = 32,
  parameter int SCK_HALF    = 4
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   job_valid_in,
  output logic                   job_ready_out,
  input  logic [JOB_BITS-1:0]    job_data_in,
  input  logic                   cancel_in,
  output logic                   result_valid_out,
  output logic [RESULT_BITS-1:0] result_data_out,
  output logic                   busy_out,
  output logic                   sck0_out,
  output logic                   sdo0_out,
  output logic                   cs0_n_out,
  output logic                   sck1_out,
  output logic                   sdo1_out,
  output logic                   cs1_n_out,
  input  logic                   sdi1_in,
  input  logic                   ready_n_in
);

  localparam int MAX_BITS = (JOB_BITS > RESULT_BITS) ? JOB_BITS : RESULT_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int HALF_W   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(SCK_HALF - 1);
  localparam logic [CNT_W-1:0]  JOB_LAST    = CNT_W'(JOB_BITS);
  localparam logic [CNT_W-1:0]  RES_LAST    = CNT_W'(RESULT_BITS);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_READY, READ, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [HALF_W-1:0]      half_reg, half_next;
  logic [CNT_W-1:0]       bit_reg, bit_next;
  logic                   sck_reg, sck_next;
  logic [JOB_BITS-1:0]    job_sr_reg, job_sr_next;
  logic [RESULT_BITS-1:0] res_sr_reg, res_sr_next;
  logic [RESULT_BITS-1:0] result_reg, result_next;
  logic                   sync0_reg, sync1_reg;
  logic                   half_done;

  assign half_done = (half_reg == '0);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg  <= IDLE;
      half_reg   <= '0;
      bit_reg    <= '0;
      sck_reg    <= 1'b0;
      job_sr_reg <= '0;
      res_sr_reg <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      half_reg   <= half_next;
      bit_reg    <= bit_next;
      sck_reg    <= sck_next;
      job_sr_reg <= job_sr_next;
      res_sr_reg <= res_sr_next;
      result_reg <= result_next;
    end
  end

  // The synchronizer is held at "not ready" outside WAIT_READY so a stale or
  // early ready_n level can only be seen after two fresh samples.
  always_ff @(posedge clk_in) begin
    if (reset_in || state_reg != WAIT_READY) begin
      sync0_reg <= 1'b1;
      sync1_reg <= 1'b1;
    end else begin
      sync0_reg <= ready_n_in;
      sync1_reg <= sync0_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    half_next   = half_reg;
    bit_next    = bit_reg;
    sck_next    = sck_reg;
    job_sr_next = job_sr_reg;
    res_sr_next = res_sr_reg;
    result_next = result_reg;

    if ((state_reg == LOAD || state_reg == READ) && !half_done)
      half_next = half_reg - 1'b1;

    case (state_reg)
      IDLE: begin
        if (job_valid_in && !cancel_in) begin
          state_next  = LOAD;
          job_sr_next = job_data_in;
          half_next   = HALF_RELOAD;
          bit_next    = '0;
          sck_next    = 1'b0;
        end
      end
      LOAD: begin
        if (half_done) begin
          half_next = HALF_RELOAD;
          if (sck_reg) begin
            sck_next    = 1'b0;
            bit_next    = bit_reg + 1'b1;
            job_sr_next = job_sr_reg << 1;
          end else if (bit_reg == JOB_LAST) begin
            state_next = WAIT_READY;
          end else begin
            sck_next = 1'b1;
          end
        end
      end
      WAIT_READY: begin
        if (!sync1_reg) begin
          state_next  = READ;
          half_next   = HALF_RELOAD;
          bit_next    = '0;
          sck_next    = 1'b0;
          res_sr_next = '0;
        end
      end
      READ: begin
        if (half_done) begin
          half_next = HALF_RELOAD;
          if (sck_reg) begin
            sck_next = 1'b0;
            bit_next = bit_reg + 1'b1;
          end else if (bit_reg == RES_LAST) begin
            state_next  = DONE;
            result_next = res_sr_reg;
          end else begin
            sck_next    = 1'b1;
            res_sr_next = (res_sr_reg << 1) | RESULT_BITS'(sdi1_in);
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (cancel_in && state_reg != IDLE) begin
      state_next = IDLE;
      sck_next   = 1'b0;
    end
  end

  assign job_ready_out    = (state_reg == IDLE);
  assign busy_out         = (state_reg != IDLE);
  assign result_valid_out = (state_reg == DONE);
  assign result_data_out  = result_reg;
  assign cs0_n_out        = (state_reg != LOAD);
  assign sck0_out         = sck_reg && (state_reg == LOAD);
  assign sdo0_out         = (state_reg == LOAD) ? job_sr_reg[JOB_BITS-1] : 1'b0;
  assign cs1_n_out        = (state_reg != READ);
  assign sck1_out         = sck_reg && (state_reg == READ);
  assign sdo1_out         = 1'b0;

endmodule

// File: tb/tb_shapool_host_spi.sv
// Bench for shapool_host_spi with a behavioural pool model on both SPI buses.
module tb_shapool_host_spi;
  localparam int JB = 8;
  localparam int RB = 8;
  localparam int H  = 2;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          job_valid_in = 1'b0;
  logic [JB-1:0] job_data_in = '0;
  logic          cancel_in = 1'b0;
  logic          sdi1_in = 1'b0;
  logic          ready_n_in = 1'b1;
  logic          job_ready_out, result_valid_out, busy_out;
  logic [RB-1:0] result_data_out;
  logic          sck0_out, sdo0_out, cs0_n_out, sck1_out, sdo1_out, cs1_n_out;

  always #5 clk_in = ~clk_in;

  shapool_host_spi #(.JOB_BITS(JB), .RESULT_BITS(RB), .SCK_HALF(H)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .job_valid_in(job_valid_in), .job_ready_out(job_ready_out), .job_data_in(job_data_in),
    .cancel_in(cancel_in), .result_valid_out(result_valid_out), .result_data_out(result_data_out),
    .busy_out(busy_out), .sck0_out(sck0_out), .sdo0_out(sdo0_out), .cs0_n_out(cs0_n_out),
    .sck1_out(sck1_out), .sdo1_out(sdo1_out), .cs1_n_out(cs1_n_out),
    .sdi1_in(sdi1_in), .ready_n_in(ready_n_in)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pool model and bus monitor, sampled mid-cycle on the falling clk edge.
  int cyc = 0, cs0_len = 0, cs0_last_len = 0, rx_cnt = 0, rise1_cnt = 0, pulse_cnt = 0;
  int tx_idx = 0, cs0_rise_cyc = 0, cs1_fall_cyc = 0;
  int viol_overlap = 0, viol_sck = 0, viol_sdo1 = 0, viol_busy = 0;
  logic prev_cs0 = 1'b1, prev_cs1 = 1'b1, prev_sck0 = 1'b0, prev_sck1 = 1'b0;
  logic [JB-1:0] rx_job = '0;
  logic [RB-1:0] pool_result = '0;

  always @(negedge clk_in) begin
    cyc++;
    if (!cs0_n_out && prev_cs0) begin cs0_len = 0; rx_cnt = 0; end
    if (!cs0_n_out) cs0_len++;
    if (cs0_n_out && !prev_cs0) begin cs0_last_len = cs0_len; cs0_rise_cyc = cyc; end
    if (sck0_out && !prev_sck0) begin rx_job = {rx_job[JB-2:0], sdo0_out}; rx_cnt++; end
    if (!cs1_n_out && prev_cs1) begin
      cs1_fall_cyc = cyc; rise1_cnt = 0; tx_idx = RB - 1; sdi1_in = pool_result[tx_idx];
    end
    if (sck1_out && !prev_sck1) rise1_cnt++;
    if (!sck1_out && prev_sck1 && !cs1_n_out && tx_idx > 0) begin
      tx_idx--; sdi1_in = pool_result[tx_idx];
    end
    if (result_valid_out) pulse_cnt++;
    if (!cs0_n_out && !cs1_n_out) viol_overlap++;
    if ((sck0_out && cs0_n_out) || (sck1_out && cs1_n_out)) viol_sck++;
    if (sdo1_out) viol_sdo1++;
    if ((!cs0_n_out || !cs1_n_out) && !busy_out) viol_busy++;
    prev_cs0 = cs0_n_out; prev_cs1 = cs1_n_out; prev_sck0 = sck0_out; prev_sck1 = sck1_out;
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic send_job(input logic [JB-1:0] d);
    int n = 0;
    while (!job_ready_out && n < 200) begin tick(); n++; end
    check("accept_timeout", int'(n < 200), 1);
    job_valid_in = 1'b1; job_data_in = d;
    tick();
    job_valid_in = 1'b0;
    check("load_cs0", int'(cs0_n_out), 0);
    check("load_msb", int'(sdo0_out), int'(d[JB-1]));
    check("load_busy", int'(busy_out), 1);
    check("load_not_ready", int'(job_ready_out), 0);
  endtask

  task automatic finish_load(input logic [JB-1:0] d);
    int n = 0;
    while (!cs0_n_out && n < 500) begin tick(); n++; end
    check("load_timeout", int'(n < 500), 1);
    check("load_data", int'(rx_job), int'(d));
    check("load_bits", rx_cnt, JB);
    check("cs0_len", cs0_last_len, H + 2 * H * JB);
    check("wait_busy", int'(busy_out), 1);
  endtask

  task automatic do_readout(input logic [RB-1:0] r);
    int n = 0;
    int p0;
    pool_result = r; p0 = pulse_cnt; ready_n_in = 1'b0;
    while (!result_valid_out && n < 1000) begin tick(); n++; end
    check("read_timeout", int'(n < 1000), 1);
    check("read_data", int'(result_data_out), int'(r));
    check("read_rises", rise1_cnt, RB);
    check("read_cs1_high", int'(cs1_n_out), 1);
    ready_n_in = 1'b1;
    tick();
    check("valid_width", int'(result_valid_out), 0);
    check("idle_after", int'(job_ready_out), 1);
    check("pulse_count", pulse_cnt - p0, 1);
    check("data_hold", int'(result_data_out), int'(r));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy_out), 0);
    check({tag, "_cs"}, int'({cs0_n_out, cs1_n_out}), 3);
    check({tag, "_sck_sdo"}, int'({sck0_out, sck1_out, sdo0_out, sdo1_out}), 0);
    check({tag, "_ready"}, int'(job_ready_out), 1);
  endtask

  initial begin
    logic [JB-1:0] d;
    logic [RB-1:0] r;
    int p0, n;

    reset_in = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    check("reset_valid", int'(result_valid_out), 0);
    check("reset_data", int'(result_data_out), 0);
    reset_in = 1'b0;
    tick();
    check("post_reset_ready", int'(job_ready_out), 1);

    send_job(8'hA5); finish_load(8'hA5); do_readout(8'h3C);

    for (int i = 0; i < 6; i++) begin
      d = JB'($urandom); r = RB'($urandom);
      send_job(d); finish_load(d);
      repeat ($urandom_range(6, 0)) tick();
      do_readout(r);
      $display("job %0d: data=%02h result=%02h", i, d, r);
    end

    // ready_n already low while the job is shifted in
    ready_n_in = 1'b0;
    d = JB'($urandom);
    send_job(d); finish_load(d); do_readout(8'h96);
    check("early_ready_gap", int'(cs1_fall_cyc - cs0_rise_cyc >= 2), 1);

    p0 = pulse_cnt;
    send_job(8'hE7);
    n = 0;
    while (rx_cnt < 4 && n < 200) begin tick(); n++; end
    cancel_in = 1'b1; tick(); cancel_in = 1'b0;
    check_idle("cancel_load");
    repeat (10) tick();
    check("cancel_load_pulse", pulse_cnt - p0, 0);

    send_job(8'h33); finish_load(8'h33);
    tick();
    cancel_in = 1'b1; tick(); cancel_in = 1'b0;
    check_idle("cancel_wait");
    ready_n_in = 1'b0;
    repeat (20) tick();
    ready_n_in = 1'b1;
    check("cancel_wait_pulse", pulse_cnt - p0, 0);
    check("cancel_wait_idle", int'(busy_out), 0);

    send_job(8'h5A); finish_load(8'h5A); do_readout(8'hC7);

    job_valid_in = 1'b1; cancel_in = 1'b1; job_data_in = 8'hFF;
    tick();
    job_valid_in = 1'b0; cancel_in = 1'b0;
    check("cancel_accept_drop", int'(busy_out), 0);
    tick();
    check("cancel_accept_idle", int'(cs0_n_out), 1);

    d = JB'($urandom);
    send_job(d); finish_load(d);
    pool_result = 8'h6B; ready_n_in = 1'b0;
    n = 0;
    while (rise1_cnt < 3 && n < 300) begin tick(); n++; end
    check("read_bit3_timeout", int'(n < 300), 1);
    reset_in = 1'b1; tick(); reset_in = 1'b0; ready_n_in = 1'b1;
    check("reset_read_cs1", int'(cs1_n_out), 1);
    check("reset_read_data", int'(result_data_out), 0);
    check("reset_read_busy", int'(busy_out), 0);
    tick();

    send_job(8'hC3);
    n = 0;
    while (rx_cnt < 2 && n < 200) begin tick(); n++; end
    job_valid_in = 1'b1; job_data_in = 8'h00;
    tick();
    job_valid_in = 1'b0;
    finish_load(8'hC3); do_readout(8'h81);

    check("cs_overlap", viol_overlap, 0);
    check("sck_without_cs", viol_sck, 0);
    check("sdo1_nonzero", viol_sdo1, 0);
    check("busy_with_cs", viol_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
